// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fb_pkg
// Description : Shared constants, pixel types and colour expansion for the
//               framebuffer scan-out path.
// Revision    : 1.0 - initial release
// ============================================================================
package fb_pkg;

    localparam int FB_W      = 320;
    localparam int FB_H      = 240;
    localparam int BUF1_BASE = FB_W * FB_H;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_PENDING = 1'b1
    } swap_state_t;

    function automatic rgb444_t rgb332_to_444(input rgb332_t p);
        rgb444_t c;
        c.r = {p.r, 1'b0};
        c.g = {p.g, 1'b0};
        c.b = {p.b, 2'b00};
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fb_scanout_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : fb_scanout_reader_if
// Description : Framebuffer port-B read bus plus the buffer-swap handshake.
// Revision    : 1.0 - initial release
// ============================================================================
interface fb_scanout_reader_if #(
    parameter int ADDR_W = 18
);
    logic [ADDR_W-1:0] fb_addrb;
    logic [7:0]        fb_doutb;
    logic              swap_req;
    logic              swap_ack;

    modport master (
        output fb_addrb,
        output swap_ack,
        input  fb_doutb,
        input  swap_req
    );

    modport slave (
        input  fb_addrb,
        input  swap_ack,
        output fb_doutb,
        output swap_req
    );
endinterface
`default_nettype wire

// File: rtl/fb_swap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fb_swap_ctrl
// Description : Vsync-synchronous front/back buffer swap and frame counter.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_swap_ctrl
    import fb_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        i_pix_ce,
    input  wire logic        i_vs_in,
    input  wire logic        i_vs_prev,
    input  wire logic        i_swap_req,
    output logic             o_swap_ack,
    output logic             o_front_sel,
    output logic [15:0]      o_frame_cnt
);

    swap_state_t r_state;
    swap_state_t w_state_nxt;
    logic        w_vs_rise;
    logic        w_do_swap;
    logic        r_swap_ack;
    logic        r_front_sel;
    logic [15:0] r_frame_cnt;

    // Edge is judged against the vsync already latched in pipeline stage 1.
    assign w_vs_rise = i_pix_ce & i_vs_in & ~i_vs_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_do_swap   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_pix_ce && i_swap_req) begin
                    w_state_nxt = S_PENDING;
                end
            end
            S_PENDING: begin
                if (w_vs_rise) begin
                    w_do_swap   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_swap_ack  <= 1'b0;
            r_front_sel <= 1'b0;
            r_frame_cnt <= 16'd0;
        end else begin
            r_swap_ack <= w_do_swap;
            if (w_do_swap) begin
                r_front_sel <= ~r_front_sel;
            end
            if (w_vs_rise) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    assign o_swap_ack  = r_swap_ack;
    assign o_front_sel = r_front_sel;
    assign o_frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: rtl/fb_scanout_reader.sv
`default_nettype none
// ============================================================================
// Module      : fb_scanout_reader
// Description : 2x-upscaled RGB332 framebuffer reader with sync alignment and
//               double-buffer swap towards the rasterizer.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_scanout_reader
    import fb_pkg::*;
#(
    parameter int FB_W      = fb_pkg::FB_W,
    parameter int FB_H      = fb_pkg::FB_H,
    parameter int ADDR_W    = 18,
    parameter int BUF1_BASE = FB_W * FB_H
) (
    input  wire logic          aclk,
    input  wire logic          arst,
    input  wire logic          pix_ce,
    input  wire logic [9:0]    drawX,
    input  wire logic [9:0]    drawY,
    input  wire logic          hs_in,
    input  wire logic          vs_in,
    input  wire logic          vde_in,
    fb_scanout_reader_if.master bus,
    output logic               front_sel,
    output logic [15:0]        frame_cnt,
    output logic [3:0]         red,
    output logic [3:0]         green,
    output logic [3:0]         blue,
    output logic               hs_out,
    output logic               vs_out,
    output logic               vde_out
);

    logic [8:0]        w_x_half;
    logic [8:0]        w_y_half;
    logic [ADDR_W-1:0] w_row_off;
    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] w_addr;
    logic              w_unused;

    logic [ADDR_W-1:0] r_addr;
    logic              r_hs1, r_vs1, r_vde1;
    logic              r_hs2, r_vs2, r_vde2;
    rgb444_t           r_rgb;

    assign w_x_half = drawX[9:1];
    assign w_y_half = drawY[9:1];
    assign w_unused = &{1'b0, drawX[0], drawY[0]};

    generate
        if (FB_W == 320) begin : g_row_shift
            assign w_row_off = ADDR_W'({w_y_half, 8'd0}) + ADDR_W'({w_y_half, 6'd0});
        end else begin : g_row_mul
            assign w_row_off = ADDR_W'(w_y_half * FB_W);
        end
    endgenerate

    assign w_base = front_sel ? ADDR_W'(BUF1_BASE) : '0;
    assign w_addr = w_base + w_row_off + ADDR_W'(w_x_half);

    // BRAM data returned one aclk after the stage-1 address is long settled
    // by the next pixel enable, so stage 2 can sample it directly.
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            r_addr <= '0;
            r_hs1  <= 1'b0;
            r_vs1  <= 1'b0;
            r_vde1 <= 1'b0;
            r_hs2  <= 1'b0;
            r_vs2  <= 1'b0;
            r_vde2 <= 1'b0;
            r_rgb  <= '0;
        end else if (pix_ce) begin
            r_addr <= w_addr;
            r_hs1  <= hs_in;
            r_vs1  <= vs_in;
            r_vde1 <= vde_in;
            r_hs2  <= r_hs1;
            r_vs2  <= r_vs1;
            r_vde2 <= r_vde1;
            r_rgb  <= r_vde1 ? rgb332_to_444(rgb332_t'(bus.fb_doutb)) : '0;
        end
    end

    fb_swap_ctrl u_swap (
        .clk         (aclk),
        .rst         (arst),
        .i_pix_ce    (pix_ce),
        .i_vs_in     (vs_in),
        .i_vs_prev   (r_vs1),
        .i_swap_req  (bus.swap_req),
        .o_swap_ack  (bus.swap_ack),
        .o_front_sel (front_sel),
        .o_frame_cnt (frame_cnt)
    );

    assign bus.fb_addrb = r_addr;
    assign red          = r_rgb.r;
    assign green        = r_rgb.g;
    assign blue         = r_rgb.b;
    assign hs_out       = r_hs2;
    assign vs_out       = r_vs2;
    assign vde_out      = r_vde2;

endmodule
`default_nettype wire

// File: tb/tb_fb_scanout_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fb_scanout_reader
// Description : Scoreboard bench for the framebuffer scan-out reader.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fb_scanout_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_ce = 1'b0;
    logic [9:0]  drawX = '0;
    logic [9:0]  drawY = '0;
    logic        hs_in = 1'b0;
    logic        vs_in = 1'b0;
    logic        vde_in = 1'b0;
    logic        front_sel;
    logic [15:0] frame_cnt;
    logic [3:0]  red, green, blue;
    logic        hs_out, vs_out, vde_out;

    fb_scanout_reader_if #(.ADDR_W(18)) bus_if();

    fb_scanout_reader dut (
        .aclk      (clk),
        .arst      (rst),
        .pix_ce    (pix_ce),
        .drawX     (drawX),
        .drawY     (drawY),
        .hs_in     (hs_in),
        .vs_in     (vs_in),
        .vde_in    (vde_in),
        .bus       (bus_if),
        .front_sel (front_sel),
        .frame_cnt (frame_cnt),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .hs_out    (hs_out),
        .vs_out    (vs_out),
        .vde_out   (vde_out)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:262143];
    always @(posedge clk) bus_if.fb_doutb <= mem[bus_if.fb_addrb];

    int n_tests = 0;
    int n_fail  = 0;
    int ack_seen = 0;
    always @(negedge clk) if (bus_if.swap_ack === 1'b1) ack_seen++;

    logic        m_front, m_pend, m_vs1;
    logic [15:0] m_frame;
    logic [17:0] m_addr;
    int          m_swaps = 0;
    logic [14:0] q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_front = 1'b0;
        m_pend  = 1'b0;
        m_vs1   = 1'b0;
        m_frame = 16'd0;
        m_addr  = 18'd0;
        q.delete();
    endtask

    // One pixel enable: drive timing, predict address/state, score the output.
    task automatic ce_cycle(input logic [9:0] x, input logic [9:0] y,
                            input logic hs, input logic vs, input logic vde, input logic req);
        logic        rise, do_swap;
        logic [7:0]  px;
        logic [11:0] rgb;
        logic [14:0] exp_o;
        int          a;
        @(negedge clk);
        drawX = x; drawY = y; hs_in = hs; vs_in = vs; vde_in = vde;
        bus_if.swap_req = req;
        pix_ce = 1'b1;
        a = (m_front ? 76800 : 0) + (int'(y) / 2) * 320 + int'(x) / 2;
        m_addr  = a[17:0];
        rise    = vs & ~m_vs1;
        do_swap = m_pend & rise;
        if (m_pend) m_pend = ~rise;
        else        m_pend = req;
        if (do_swap) begin
            m_front = ~m_front;
            m_swaps++;
        end
        if (rise) m_frame = m_frame + 16'd1;
        m_vs1 = vs;
        px  = mem[m_addr];
        rgb = vde ? {px[7:5], 1'b0, px[4:2], 1'b0, px[1:0], 2'b00} : 12'h000;
        q.push_back({rgb, hs, vs, vde});
        @(negedge clk);
        pix_ce = 1'b0;
        check("addr", 32'(bus_if.fb_addrb), 32'(m_addr));
        check("swap_ack", 32'(bus_if.swap_ack), 32'(do_swap));
        check("front_sel", 32'(front_sel), 32'(m_front));
        check("frame_cnt", 32'(frame_cnt), 32'(m_frame));
        if (q.size() == 2) begin
            exp_o = q.pop_front();
            check("pixel{rgb,hs,vs,vde}", 32'({red, green, blue, hs_out, vs_out, vde_out}), 32'(exp_o));
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500us;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int a = 0; a < 262144; a++) mem[a] = 8'(a * 37 + (a >> 8));
        mem[0] = 8'hE3;
        mem[2] = 8'hFF;
        bus_if.swap_req = 1'b0;
        model_reset();

        repeat (3) @(negedge clk);
        check("reset addr", 32'(bus_if.fb_addrb), 32'd0);
        check("reset misc", 32'({red, green, blue, hs_out, vs_out, vde_out, bus_if.swap_ack, front_sel}), 32'd0);
        check("reset frame_cnt", 32'(frame_cnt), 32'd0);
        rst = 1'b0;

        // Address map and colour/latency
        ce_cycle(10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("map(0,0)", 32'(bus_if.fb_addrb), 32'd0);
        ce_cycle(10'd1, 10'd1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("map(1,1)", 32'(bus_if.fb_addrb), 32'd0);
        check("rgb of E3", 32'({red, green, blue}), 32'h0E0C);
        check("vde_out with E3", 32'(vde_out), 32'd1);
        ce_cycle(10'd639, 10'd479, 1'b0, 1'b0, 1'b1, 1'b0);
        check("map(639,479)", 32'(bus_if.fb_addrb), 32'd76799);
        ce_cycle(10'd2, 10'd2, 1'b0, 1'b0, 1'b1, 1'b0);
        check("map(2,2)", 32'(bus_if.fb_addrb), 32'd321);

        // Blanking over a 0xFF word with a 3-enable hsync pulse
        for (int i = 0; i < 8; i++)
            ce_cycle(10'd4, 10'd0, (i >= 2 && i < 5), 1'b0, 1'b0, 1'b0);
        check("blank rgb", 32'({red, green, blue}), 32'd0);

        for (int i = 0; i < 24; i++)
            ce_cycle(10'($urandom_range(0, 639)), 10'($urandom_range(0, 479)), 1'b0, 1'b0, 1'b1, 1'b0);

        // Mid-frame request waits for vsync; held request swaps again next frame
        for (int i = 0; i < 4; i++) ce_cycle(10'd10, 10'd10, 1'b0, 1'b0, 1'b1, 1'b1);
        check("no swap before vs", 32'(front_sel), 32'd0);
        ce_cycle(10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("swap1 front_sel", 32'(front_sel), 32'd1);
        ce_cycle(10'd639, 10'd479, 1'b0, 1'b1, 1'b0, 1'b1);
        check("map buf1 (639,479)", 32'(bus_if.fb_addrb), 32'd153599);
        for (int i = 0; i < 4; i++) ce_cycle(10'd20, 10'd20, 1'b0, 1'b0, 1'b1, 1'b1);
        check("held req no early swap", 32'(front_sel), 32'd1);
        ce_cycle(10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("swap2 front_sel", 32'(front_sel), 32'd0);

        // Request rising together with the vsync edge is deferred one frame
        ce_cycle(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        ce_cycle(10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("simultaneous req no swap", 32'(front_sel), 32'd0);
        ce_cycle(10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        ce_cycle(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        ce_cycle(10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("swap3 front_sel", 32'(front_sel), 32'd1);

        // Enable held low: vsync toggling and a request must change nothing
        bus_if.swap_req = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            vs_in = ~vs_in;
        end
        check("frozen front_sel", 32'(front_sel), 32'(m_front));
        check("frozen frame_cnt", 32'(frame_cnt), 32'(m_frame));
        check("frozen addr", 32'(bus_if.fb_addrb), 32'(m_addr));
        check("frozen ack count", 32'(ack_seen), 32'(m_swaps));
        bus_if.swap_req = 1'b0;

        // Frame counter wrap from a preset value
        @(negedge clk);
        force dut.u_swap.r_frame_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.u_swap.r_frame_cnt;
        m_frame = 16'hFFFF;
        @(negedge clk);
        check("frame_cnt preset", 32'(frame_cnt), 32'h0000FFFF);
        ce_cycle(10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        ce_cycle(10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("frame_cnt wrap", 32'(frame_cnt), 32'd0);
        ce_cycle(10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        ce_cycle(10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        ce_cycle(10'd2, 10'd0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-line
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid reset addr", 32'(bus_if.fb_addrb), 32'd0);
        check("mid reset misc", 32'({red, green, blue, hs_out, vs_out, vde_out, bus_if.swap_ack, front_sel}), 32'd0);
        check("mid reset frame_cnt", 32'(frame_cnt), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        ce_cycle(10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        ce_cycle(10'd6, 10'd8, 1'b0, 1'b0, 1'b1, 1'b0);
        check("post reset rgb", 32'({red, green, blue}), 32'h0E0C);
        for (int i = 0; i < 8; i++)
            ce_cycle(10'($urandom_range(0, 639)), 10'($urandom_range(0, 479)), 1'(i % 2), 1'b0, 1'b1, 1'b0);

        repeat (4) @(negedge clk);
        check("swap_ack pulse count", 32'(ack_seen), 32'(m_swaps));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
